// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: walks num_cout output channels, each accumulating over
// num_cin input channels, and drives the datapath strobes and store handshake.
module conv_layer_sequencer #(
  parameter int unsigned CH_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [CH_W-1:0] cfg_num_cin,
  input  logic [CH_W-1:0] cfg_num_cout,
  input  logic            cfg_relu_en,
  input  logic            conv_done,
  input  logic            store_ready,
  output logic            busy,
  output logic            c_load,
  output logic            bias_init,
  output logic            cin,
  output logic            conv,
  output logic            relu,
  output logic            cout,
  output logic            conv_start,
  output logic            store_valid,
  output logic [CH_W-1:0] cin_idx,
  output logic [CH_W-1:0] cout_idx,
  output logic            last_cin,
  output logic            done
);

  typedef enum logic [3:0] {
    StIdle,
    StChLoad,
    StBias,
    StConv,
    StCountIn,
    StActivate,
    StStore,
    StCountOut,
    StDone
  } state_e;

  localparam logic [CH_W-1:0] One = CH_W'(1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] ncin_q, ncin_d;
  logic [CH_W-1:0] ncout_q, ncout_d;
  logic [CH_W-1:0] cin_q, cin_d;
  logic [CH_W-1:0] cout_q, cout_d;
  logic            relu_en_q, relu_en_d;
  logic            conv_first_q, conv_first_d;
  logic            last_cin_w, last_cout_w;

  // Latched counts are never 0, so count-1 never underflows once a layer has started.
  assign last_cin_w  = (cin_q == ncin_q - One);
  assign last_cout_w = (cout_q == ncout_q - One);

  // Next-state, counter and configuration update; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    ncin_d    = ncin_q;
    ncout_d   = ncout_q;
    cin_d     = cin_q;
    cout_d    = cout_q;
    relu_en_d = relu_en_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StChLoad;
          ncin_d    = (cfg_num_cin == '0) ? One : cfg_num_cin;
          ncout_d   = (cfg_num_cout == '0) ? One : cfg_num_cout;
          relu_en_d = cfg_relu_en;
          cin_d     = '0;
          cout_d    = '0;
        end
      end
      StChLoad: state_d = StBias;
      StBias:   state_d = StConv;
      StConv: begin
        if (conv_done) begin
          if (!last_cin_w) begin
            state_d = StCountIn;
          end else if (relu_en_q) begin
            state_d = StActivate;
          end else begin
            state_d = StStore;
          end
        end
      end
      StCountIn: begin
        cin_d   = cin_q + One;
        state_d = StConv;
      end
      StActivate: state_d = StStore;
      StStore: begin
        if (store_ready) begin
          state_d = last_cout_w ? StDone : StCountOut;
        end
      end
      StCountOut: begin
        cout_d  = cout_q + One;
        cin_d   = '0;
        state_d = StChLoad;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      cin_d   = '0;
      cout_d  = '0;
    end
  end

  // conv_start is registered so it stays a pure Moore output of the first CONV cycle.
  always_comb begin
    conv_first_d = (state_d == StConv) && (state_q != StConv);
  end

  // State, counters and latched configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ncin_q       <= '0;
      ncout_q      <= '0;
      cin_q        <= '0;
      cout_q       <= '0;
      relu_en_q    <= 1'b0;
      conv_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ncin_q       <= ncin_d;
      ncout_q      <= ncout_d;
      cin_q        <= cin_d;
      cout_q       <= cout_d;
      relu_en_q    <= relu_en_d;
      conv_first_q <= conv_first_d;
    end
  end

  // Moore output decode.
  always_comb begin
    busy        = (state_q != StIdle);
    c_load      = (state_q == StChLoad);
    bias_init   = (state_q == StBias);
    cin         = (state_q == StCountIn);
    conv        = (state_q == StConv);
    relu        = (state_q == StActivate);
    cout        = (state_q == StCountOut);
    conv_start  = conv_first_q;
    store_valid = (state_q == StStore);
    done        = (state_q == StDone);
    cin_idx     = cin_q;
    cout_idx    = cout_q;
    last_cin    = last_cin_w;
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: per-cycle vector table plus hand-written
// sequences for accumulation, backpressure, abort and asynchronous reset.
module tb_conv_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, cfg_relu_en, conv_done, store_ready;
  logic [7:0] cfg_num_cin, cfg_num_cout;
  logic       busy, c_load, bias_init, cin, conv, relu, cout, conv_start, store_valid;
  logic       last_cin, done;
  logic [7:0] cin_idx, cout_idx;
  logic [10:0] flags;

  conv_layer_sequencer #(.CH_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_cin(cfg_num_cin), .cfg_num_cout(cfg_num_cout), .cfg_relu_en(cfg_relu_en),
    .conv_done(conv_done), .store_ready(store_ready),
    .busy(busy), .c_load(c_load), .bias_init(bias_init), .cin(cin), .conv(conv),
    .relu(relu), .cout(cout), .conv_start(conv_start), .store_valid(store_valid),
    .cin_idx(cin_idx), .cout_idx(cout_idx), .last_cin(last_cin), .done(done)
  );

  always #5 clk = ~clk;

  assign flags = {busy, c_load, bias_init, cin, conv, relu, cout, conv_start, store_valid,
                  done, last_cin};

  localparam logic [10:0] FB  = 11'h400, FCL = 11'h200, FBI = 11'h100, FCI = 11'h080;
  localparam logic [10:0] FCV = 11'h040, FRL = 11'h020, FCO = 11'h010, FCS = 11'h008;
  localparam logic [10:0] FSV = 11'h004, FDN = 11'h002, FLC = 11'h001;

  typedef struct {
    logic       start;
    logic       conv_done;
    logic       store_ready;
    logic [7:0] ncin;
    logic [7:0] ncout;
    logic       relu;
    logic [10:0] ef;
    logic [7:0] ecin;
    logic [7:0] ecout;
  } vec_t;

  vec_t vq[$];
  int errs = 0;
  int checks = 0;

  int cnt_cin, cnt_cout, cnt_cs, cnt_relu, cnt_sv, cnt_done, cnt_hs;
  int cycle, last_hs_cyc, last_done_cyc, sv_run, sr_wait;
  int cs_cin_q[$];
  int cl_cout_q[$];

  function automatic vec_t v(logic s, logic cd, logic sr, logic [7:0] ni, logic [7:0] no,
                             logic r, logic [10:0] ef, logic [7:0] ec, logic [7:0] eo);
    vec_t t;
    t.start = s; t.conv_done = cd; t.store_ready = sr;
    t.ncin = ni; t.ncout = no; t.relu = r;
    t.ef = ef; t.ecin = ec; t.ecout = eo;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_cin = 0; cnt_cout = 0; cnt_cs = 0; cnt_relu = 0; cnt_sv = 0; cnt_done = 0;
    cnt_hs = 0; last_hs_cyc = -1; last_done_cyc = -2; sv_run = 0;
    cs_cin_q.delete();
    cl_cout_q.delete();
  endtask

  // One clock: note handshake on the edge, then sample outputs 1 time unit later.
  task automatic cyc();
    logic hs;
    hs = store_valid && store_ready;
    @(posedge clk);
    #1;
    cycle++;
    if (hs) begin cnt_hs++; last_hs_cyc = cycle; end
    if (cin) cnt_cin++;
    if (cout) cnt_cout++;
    if (relu) cnt_relu++;
    if (store_valid) cnt_sv++;
    if (done) begin cnt_done++; last_done_cyc = cycle; end
    if (conv_start) begin cnt_cs++; cs_cin_q.push_back(int'(cin_idx)); end
    if (c_load) cl_cout_q.push_back(int'(cout_idx));
  endtask

  // Simple datapath model: CONV lasts 2 cycles, store_ready after sr_wait stalled cycles.
  task automatic respond();
    conv_done = conv && !conv_start;
    if (store_valid) sv_run++; else sv_run = 0;
    store_ready = store_valid && (sv_run > sr_wait);
  endtask

  task automatic run_until_idle(string nm, int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      respond();
      cyc();
      start = 1'b0;
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({nm, " reached idle"}, int'(ok), 1);
    conv_done = 1'b0;
    store_ready = 1'b0;
  endtask

  task automatic set_cfg(logic [7:0] ni, logic [7:0] no, logic r);
    cfg_num_cin = ni; cfg_num_cout = no; cfg_relu_en = r;
  endtask

  initial begin
    int exp_cin[6];
    bit found;
    exp_cin = '{0, 1, 2, 0, 1, 2};
    cycle = 0; sr_wait = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; conv_done = 1'b0; store_ready = 1'b0;
    set_cfg(8'd0, 8'd0, 1'b0);
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    chk("reset flags", int'(flags), 0);
    chk("reset cin_idx", int'(cin_idx), 0);
    chk("reset cout_idx", int'(cout_idx), 0);
    rst = 1'b0;

    // Minimal layer 1/1 relu, CONV x4, store_ready high.
    vq.push_back(v(1, 0, 1, 1, 1, 1, FB | FCL | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FBI | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FCV | FCS | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FCV | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FCV | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FCV | FLC, 0, 0));
    vq.push_back(v(0, 1, 1, 1, 1, 1, FB | FRL | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FSV | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FB | FDN | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 1, 1, 1, FLC, 0, 0));
    // Zero config behaves as 1/1; later cfg changes and conv_done in BIAS are ignored;
    // conv_done together with conv_start exits CONV.
    vq.push_back(v(1, 0, 0, 0, 0, 0, FB | FCL | FLC, 0, 0));
    vq.push_back(v(0, 0, 0, 7, 7, 1, FB | FBI | FLC, 0, 0));
    vq.push_back(v(0, 1, 0, 7, 7, 1, FB | FCV | FCS | FLC, 0, 0));
    vq.push_back(v(0, 1, 0, 7, 7, 1, FB | FSV | FLC, 0, 0));
    vq.push_back(v(0, 0, 0, 7, 7, 1, FB | FSV | FLC, 0, 0));
    vq.push_back(v(0, 0, 1, 7, 7, 1, FB | FDN | FLC, 0, 0));
    vq.push_back(v(0, 0, 0, 7, 7, 1, FLC, 0, 0));

    foreach (vq[i]) begin
      start = vq[i].start; conv_done = vq[i].conv_done; store_ready = vq[i].store_ready;
      set_cfg(vq[i].ncin, vq[i].ncout, vq[i].relu);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d flags", i), int'(flags), int'(vq[i].ef));
      chk($sformatf("vec%0d cin_idx", i), int'(cin_idx), int'(vq[i].ecin));
      chk($sformatf("vec%0d cout_idx", i), int'(cout_idx), int'(vq[i].ecout));
    end
    start = 1'b0; conv_done = 1'b0; store_ready = 1'b0;

    // Accumulation: 3 input channels, 2 output channels.
    clr_counts(); sr_wait = 0;
    set_cfg(8'd3, 8'd2, 1'b1);
    start = 1'b1;
    run_until_idle("accum", 200);
    chk("accum cin pulses", cnt_cin, 4);
    chk("accum cout pulses", cnt_cout, 1);
    chk("accum handshakes", cnt_hs, 2);
    chk("accum conv_start", cnt_cs, 6);
    chk("accum relu", cnt_relu, 2);
    chk("accum done", cnt_done, 1);
    chk("accum cin seq len", cs_cin_q.size(), 6);
    for (int i = 0; i < 6 && i < cs_cin_q.size(); i++)
      chk($sformatf("accum cin_idx[%0d]", i), cs_cin_q[i], exp_cin[i]);
    chk("accum c_load count", cl_cout_q.size(), 2);
    for (int i = 0; i < 2 && i < cl_cout_q.size(); i++)
      chk($sformatf("accum cout_idx[%0d]", i), cl_cout_q[i], i);
    chk("accum final cin_idx", int'(cin_idx), 2);
    chk("accum final cout_idx", int'(cout_idx), 1);

    // ReLU bypass with 5 cycles of store backpressure.
    clr_counts(); sr_wait = 5;
    set_cfg(8'd1, 8'd1, 1'b0);
    start = 1'b1;
    run_until_idle("bypass", 200);
    chk("bypass relu", cnt_relu, 0);
    chk("bypass store_valid cycles", cnt_sv, 6);
    chk("bypass handshakes", cnt_hs, 1);
    chk("bypass done", cnt_done, 1);
    chk("bypass done after hs", last_done_cyc - last_hs_cyc, 0);

    // Stray start/conv_done in BIAS, then abort in CONV with cout_idx 2.
    clr_counts(); sr_wait = 0;
    set_cfg(8'd1, 8'd4, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("ign in bias", int'(flags), int'(FB | FBI | FLC));
    start = 1'b1; conv_done = 1'b1;
    cyc();
    start = 1'b0; conv_done = 1'b0;
    chk("ign conv entry", int'(flags), int'(FB | FCV | FCS | FLC));
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (conv && cout_idx == 8'd2) begin found = 1'b1; break; end
      respond();
      cyc();
    end
    chk("abort reached cout 2", int'(found), 1);
    abort = 1'b1; conv_done = 1'b0; store_ready = 1'b0;
    cyc();
    abort = 1'b0;
    chk("abort flags", int'(flags), int'(FLC));
    chk("abort cin_idx", int'(cin_idx), 0);
    chk("abort cout_idx", int'(cout_idx), 0);
    repeat (4) cyc();
    chk("abort no done", cnt_done, 0);
    chk("abort stays idle", int'(busy), 0);
    clr_counts();
    set_cfg(8'd2, 8'd1, 1'b1);
    start = 1'b1;
    run_until_idle("post-abort", 200);
    chk("post-abort done", cnt_done, 1);
    chk("post-abort conv_start", cnt_cs, 2);

    // Asynchronous reset while waiting in STORE.
    clr_counts(); sr_wait = 100;
    set_cfg(8'd1, 8'd1, 1'b0);
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      respond();
      cyc();
      start = 1'b0;
      if (store_valid) begin found = 1'b1; break; end
    end
    chk("rst reached store", int'(found), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst flags", int'(flags), 0);
    chk("async rst cout_idx", int'(cout_idx), 0);
    #2;
    rst = 1'b0; store_ready = 1'b0; conv_done = 1'b0;
    clr_counts(); sr_wait = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rst restart c_load", int'(flags), int'(FB | FCL | FLC));
    run_until_idle("rst restart", 200);
    chk("rst restart done", cnt_done, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Parametrised top-level controller for the convolution layer. It sequences a full layer of `num_cout` output channels, each accumulating over `num_cin` input channels, and owns the channel counters and handshakes instead of taking done flags from outside. Per layer it adds runtime configuration, an optional ReLU bypass, a ready/valid store handshake to the output memory, and a synchronous abort. It sits between the layer start logic and the conv datapath (patch engine, bias/accumulator, activation, output writer).

## Interface
- `CH_W`, default 8: width of channel counters and configuration fields.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  layer start; accepted only in IDLE.
- `abort`  in  1  synchronous abort; returns the block to IDLE from any state.
- `cfg_num_cin`  in  CH_W  input channel count; latched on start; 0 is treated as 1.
- `cfg_num_cout`  in  CH_W  output channel count; latched on start; 0 is treated as 1.
- `cfg_relu_en`  in  1  latched on start; 0 bypasses ACTIVATE.
- `conv_done`  in  1  datapath finished all patches for the current (cin, cout) pair.
- `store_ready`  in  1  output writer accepts the channel result.
- `busy`  out  1  high in every state except IDLE.
- `c_load`, `bias_init`, `cin`, `conv`, `relu`, `cout`  out  1 each  one-hot state strobes; each is high only in its own state.
- `conv_start`  out  1  high only in the first cycle of each CONV visit.
- `store_valid`  out  1  high throughout STORE.
- `cin_idx`  out  CH_W  current input channel index.
- `cout_idx`  out  CH_W  current output channel index.
- `last_cin`  out  1  `cin_idx == ncin-1`.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, CHANNEL_LOAD, BIAS_STORE, CONV, COUNT_IN, ACTIVATE, STORE, COUNT_OUT, DONE.
- All outputs are Moore outputs decoded from state, or from registered counters.
- The latched `ncin` and `ncout` equal the configured value, or 1 if the configured value was 0.
- IDLE: on `start`, latch the configuration, clear both indices, and go to CHANNEL_LOAD.
- CHANNEL_LOAD: 1 cycle, then BIAS_STORE.
- BIAS_STORE: 1 cycle, then CONV.
- CONV: hold until `conv_done`.
  - If `last_cin` is 0, go to COUNT_IN.
  - If `last_cin` is 1 and `relu_en` is 1, go to ACTIVATE.
  - If `last_cin` is 1 and `relu_en` is 0, go to STORE.
- COUNT_IN: `cin_idx` increments by 1; 1 cycle, then CONV.
- ACTIVATE: 1 cycle, then STORE.
- STORE: hold `store_valid` until `store_ready`.
  - On the handshake, go to DONE if `cout_idx == ncout-1`, else COUNT_OUT.
- COUNT_OUT: `cout_idx` increments by 1 and `cin_idx` clears to 0; 1 cycle, then CHANNEL_LOAD.
- DONE: 1 cycle, then IDLE. Indices keep their final values until the next start.
- `abort` has priority over every transition, including start in IDLE.
  - Next state is IDLE; indices clear.
  - No `done` pulse and no further strobes.
- `start` in any state other than IDLE is ignored. Configuration inputs are ignored outside the start cycle.
- `conv_done` outside CONV is ignored.
- `store_ready` outside STORE is ignored.
- `conv_done` in the same cycle as `conv_start` is valid and is acted on.
- Counters never wrap. Maximum `ncin` and `ncout` is 2^CH_W−1.

## Timing
- Reset value of every output is 0; the state resets to IDLE.
- Start latency: `start` sampled at edge E0 gives `c_load` in cycle 1, `bias_init` in cycle 2, and `conv` with `conv_start` in cycle 3.
- CONV exit: `conv_done` sampled at edge E moves the state on the next cycle (COUNT_IN, ACTIVATE or STORE).
- COUNT_IN to CONV: `cin_idx` is already incremented in the CONV cycle that has `conv_start`.
- Store handshake: a transfer occurs at an edge where `store_valid` and `store_ready` are both high.
  - `store_ready` held high on STORE entry gives a 1-cycle STORE.
- Minimum cycles per output channel: 5 + 2·(ncin−1) + relu_en, plus the CONV wait and the STORE wait. DONE adds 1 cycle per layer.
- Reset mid-operation takes effect immediately (asynchronous): all outputs drop to 0 within the same cycle.

## Test plan
- Minimal layer: ncin=1, ncout=1, relu=1, `conv_done` 4 cycles after `conv_start`, `store_ready` tied 1.
  - Required states: c_load, bias_init, CONV×4, relu, STORE×1, then `done` 9 cycles after start sampling; `busy` falls the cycle after that.
- Accumulation: ncin=3, ncout=2.
  - Required: `cin` pulses 2× per output channel; `cin_idx` sequence 0,1,2 per channel.
  - Required: `cout` pulses exactly once, with `cout_idx` 0→1; exactly 2 `store_valid` handshakes; `conv_start` count 6.
- ReLU bypass and backpressure: relu_en=0, `store_ready` low for 5 cycles.
  - Required: no `relu` strobe; `store_valid` held 6 cycles; `done` after the handshake.
- Zero config: cfg_num_cin=0, cfg_num_cout=0.
  - Required: behaves as 1/1 (single CONV visit, one STORE, one `done`).
- Abort and ignore:
  - `start` and stray `conv_done` pulses during BIAS_STORE: no effect.
  - `abort` in CONV with ncout=4, `cout_idx`=2: next cycle IDLE, indices 0, no `done`; a new `start` runs a clean layer.
- Async reset: assert `rst` in STORE between clock edges.
  - Required: outputs 0 immediately; after release the block is in IDLE and accepts `start`.
